imm_extend_arbiter: RTL and testbench

- Owns the immediate-extension datapath and shares it between two requesters: req0 is the decode stage and req1 is the early-branch-target unit.
- Arbitrates round-robin and extracts the immediate field selected by a format code.
- Sign- or zero-extends the field to WIDTHOUT, applies the branch shift or MOVZ shift, and returns the result through a one-entry registered output with a valid/ready handshake.
- Sits between the IF/ID boundary and the ID/EX pipeline register.

---
 rtl/imm_extend_arbiter.sv | 158 +++++++++++++++
 tb/tb_imm_extend_arbiter.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_extend_arbiter.sv
// Two-requester round-robin immediate extender with a one-entry valid/ready output register.
// Optional illegal-format reporting (out_err, err_count) is enabled by defining IMM_EXT_ERR_CHECK_EN.
module imm_extend_arbiter #(
  parameter int WIDTHOUT = 64,
  parameter int INSTR_W  = 32,
  parameter int TAG_W    = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                flush,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [INSTR_W-1:0]  req0_instr,
  input  logic [2:0]          req0_fmt,
  input  logic [TAG_W-1:0]    req0_tag,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [INSTR_W-1:0]  req1_instr,
  input  logic [2:0]          req1_fmt,
  input  logic [TAG_W-1:0]    req1_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTHOUT-1:0] out_imm,
  output logic                out_src,
  output logic [TAG_W-1:0]    out_tag,
  output logic                busy
`ifdef IMM_EXT_ERR_CHECK_EN
  ,
  output logic                out_err,
  output logic [7:0]          err_count
`endif
);

  // Handshake: a request transfers on a rising edge where reqN_valid and reqN_ready
  // are both high; a result transfers on an edge where out_valid and out_ready are high.
  typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

  state_t                state_q;
  logic [WIDTHOUT-1:0]   imm_q;
  logic                  src_q;
  logic [TAG_W-1:0]      tag_q;
  logic                  last_grant_q;

  logic                  can_accept;
  logic                  grant0;
  logic                  grant1;
  logic                  accept;
  logic                  sel_src;
  logic [INSTR_W-1:0]    sel_instr;
  logic [2:0]            sel_fmt;
  logic [TAG_W-1:0]      sel_tag;
  logic [WIDTHOUT-1:0]   imm_d;
  logic                  illegal_d;
  logic                  unused_instr_bits;

  // Reset holds both readies low so nothing is granted while reset is asserted.
  assign can_accept = reset_n & ~flush & ((state_q == S_EMPTY) | out_ready);

  // On a tie the requester not granted last wins.
  assign grant0 = req0_valid & (~req1_valid | last_grant_q);
  assign grant1 = req1_valid & (~req0_valid | ~last_grant_q);

  assign req0_ready = grant0 & can_accept;
  assign req1_ready = grant1 & can_accept;
  assign accept     = req0_ready | req1_ready;
  assign sel_src    = req1_ready;

  assign sel_instr = sel_src ? req1_instr : req0_instr;
  assign sel_fmt   = sel_src ? req1_fmt   : req0_fmt;
  assign sel_tag   = sel_src ? req1_tag   : req0_tag;

  assign unused_instr_bits = ^sel_instr[INSTR_W-1:26];

  // Field extraction and extension; concatenations fold the post-extension shift in,
  // dropping anything pushed past the top bit.
  always_comb begin
    imm_d     = '0;
    illegal_d = 1'b0;
    case (sel_fmt)
      3'd0: imm_d = {{(WIDTHOUT-12){1'b0}}, sel_instr[21:10]};
      3'd1: imm_d = {{(WIDTHOUT-9){sel_instr[20]}}, sel_instr[20:12]};
      3'd2: imm_d = {{(WIDTHOUT-21){sel_instr[23]}}, sel_instr[23:5], 2'b00};
      3'd3: imm_d = {{(WIDTHOUT-28){sel_instr[25]}}, sel_instr[25:0], 2'b00};
      3'd4: imm_d = {{(WIDTHOUT-16){1'b0}}, sel_instr[20:5]} << {sel_instr[22:21], 4'b0000};
      default: begin
        imm_d     = '0;
        illegal_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_EMPTY;
      imm_q        <= '0;
      src_q        <= 1'b0;
      tag_q        <= '0;
      last_grant_q <= 1'b1;
    end else if (flush) begin
      state_q <= S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (accept) begin
            state_q      <= S_FULL;
            imm_q        <= imm_d;
            src_q        <= sel_src;
            tag_q        <= sel_tag;
            last_grant_q <= sel_src;
          end
        end
        S_FULL: begin
          if (accept) begin
            imm_q        <= imm_d;
            src_q        <= sel_src;
            tag_q        <= sel_tag;
            last_grant_q <= sel_src;
          end else if (out_ready) begin
            state_q <= S_EMPTY;
          end
        end
        default: state_q <= S_EMPTY;
      endcase
    end
  end

  assign out_valid = (state_q == S_FULL);
  assign busy      = out_valid;
  assign out_imm   = imm_q;
  assign out_src   = src_q;
  assign out_tag   = tag_q;

`ifdef IMM_EXT_ERR_CHECK_EN
  logic       err_q;
  logic [7:0] err_count_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      err_q       <= 1'b0;
      err_count_q <= 8'd0;
    end else if (flush) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= illegal_d;
      if (illegal_d && (err_count_q != 8'hFF)) begin
        err_count_q <= err_count_q + 8'd1;
      end
    end
  end

  assign out_err   = err_q;
  assign err_count = err_count_q;
`else
  logic unused_illegal;
  assign unused_illegal = illegal_d;
`endif

endmodule

// File: tb/tb_imm_extend_arbiter.sv
// Bench for imm_extend_arbiter: per-requester expected queues checked by a negedge scoreboard,
// plus scenario tasks with inline checks. Define IMM_EXT_ERR_CHECK_EN to also cover out_err/err_count.
module tb_imm_extend_arbiter;
  localparam int W  = 64;
  localparam int TW = 4;

  logic          clk;
  logic          reset_n;
  logic          flush;
  logic          req0_valid;
  logic          req0_ready;
  logic [31:0]   req0_instr;
  logic [2:0]    req0_fmt;
  logic [TW-1:0] req0_tag;
  logic          req1_valid;
  logic          req1_ready;
  logic [31:0]   req1_instr;
  logic [2:0]    req1_fmt;
  logic [TW-1:0] req1_tag;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_imm;
  logic          out_src;
  logic [TW-1:0] out_tag;
  logic          busy;
`ifdef IMM_EXT_ERR_CHECK_EN
  logic          out_err;
  logic [7:0]    err_count;
`endif

  imm_extend_arbiter #(.WIDTHOUT(W), .INSTR_W(32), .TAG_W(TW)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_instr(req0_instr),
    .req0_fmt(req0_fmt), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_instr(req1_instr),
    .req1_fmt(req1_fmt), .req1_tag(req1_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
    .out_src(out_src), .out_tag(out_tag), .busy(busy)
`ifdef IMM_EXT_ERR_CHECK_EN
    , .out_err(out_err), .err_count(err_count)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [W+TW-1:0] exp_q0[$];
  logic [W+TW-1:0] exp_q1[$];
  logic            src_log[$];
  bit              log_en;
  bit              rnd_done;
  logic [W+TW-1:0] mon_exp;

  // Reference immediate built with integer arithmetic.
  function automatic logic [63:0] ref_imm(input logic [31:0] i, input logic [2:0] f);
    longint v;
    case (f)
      3'd0: v = longint'(i[21:10]);
      3'd1: begin
        v = longint'(i[20:12]);
        if (i[20]) v = v - 512;
      end
      3'd2: begin
        v = longint'(i[23:5]);
        if (i[23]) v = v - (longint'(1) << 19);
        v = v * 4;
      end
      3'd3: begin
        v = longint'(i[25:0]);
        if (i[25]) v = v - (longint'(1) << 26);
        v = v * 4;
      end
      3'd4: v = longint'(i[20:5]) << (16 * i[22:21]);
      default: v = 0;
    endcase
    return 64'(v);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit s, input logic [31:0] ins, input logic [2:0] f,
                         input logic [TW-1:0] t);
    if (s) begin
      req1_valid = 1'b1; req1_instr = ins; req1_fmt = f; req1_tag = t;
      exp_q1.push_back({t, ref_imm(ins, f)});
    end else begin
      req0_valid = 1'b1; req0_instr = ins; req0_fmt = f; req0_tag = t;
      exp_q0.push_back({t, ref_imm(ins, f)});
    end
  endtask

  // Drives one request and returns at posedge+1 after the accepting edge.
  task automatic send(input bit s, input logic [31:0] ins, input logic [2:0] f,
                      input logic [TW-1:0] t);
    bit got;
    set_req(s, ins, f, t);
    got = 1'b0;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      got = s ? req1_ready : req0_ready;
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL send_timeout req%0d tag=%h got ready=0 required ready=1", s, t);
    end
    step();
    if (s) req1_valid = 1'b0;
    else   req0_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int n = 0; n < 50 && (exp_q0.size() + exp_q1.size()) != 0; n++) step();
    step();
  endtask

  // ---------------- scoreboard ----------------
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (reset_n && out_valid && out_ready) begin
        if (log_en) src_log.push_back(out_src);
        checks++;
        if ((out_src ? exp_q1.size() : exp_q0.size()) == 0) begin
          failures++;
          $display("FAIL sb_unexpected src=%0d tag=%h imm=%h required no result", out_src,
                   out_tag, out_imm);
        end else begin
          mon_exp = out_src ? exp_q1.pop_front() : exp_q0.pop_front();
          if ({out_tag, out_imm} !== mon_exp) begin
            failures++;
            $display("FAIL sb_result src=%0d got tag=%h imm=%h required tag=%h imm=%h",
                     out_src, out_tag, out_imm, mon_exp[W+TW-1:W], mon_exp[W-1:0]);
          end
        end
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 1'b0; flush = 1'b1; out_ready = 1'b1;
    req0_valid = 1'b1; req0_instr = '0; req0_fmt = '0; req0_tag = '0;
    req1_valid = 1'b1; req1_instr = '0; req1_fmt = '0; req1_tag = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b required=0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b required=0", busy); end
    checks++; if (out_imm !== '0) begin failures++; $display("FAIL rst_imm got=%h required=0", out_imm); end
    checks++; if (out_src !== 1'b0) begin failures++; $display("FAIL rst_src got=%b required=0", out_src); end
    checks++; if (out_tag !== '0) begin failures++; $display("FAIL rst_tag got=%h required=0", out_tag); end
    checks++; if ({req0_ready, req1_ready} !== 2'b00) begin failures++; $display("FAIL rst_ready got=%b required=00", {req0_ready, req1_ready}); end
`ifdef IMM_EXT_ERR_CHECK_EN
    checks++; if ({out_err, err_count} !== 9'd0) begin failures++; $display("FAIL rst_err got=%b/%0d required=0/0", out_err, err_count); end
`endif
    step();
    reset_n = 1'b1; flush = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    step();
  endtask

  task automatic test_formats();
    logic [31:0] ins[6];
    logic [2:0]  fm[6];
    bit          sr[6];
    logic [63:0] want[6];
    ins[0] = 32'h1FF << 12;                    fm[0] = 3'd1; sr[0] = 0; want[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    ins[1] = 32'h40000 << 5;                   fm[1] = 3'd2; sr[1] = 1; want[1] = 64'hFFFF_FFFF_FFF0_0000;
    ins[2] = 32'hFFF << 10;                    fm[2] = 3'd0; sr[2] = 0; want[2] = 64'h0000_0000_0000_0FFF;
    ins[3] = (32'hBEEF << 5) | (32'h2 << 21);  fm[3] = 3'd4; sr[3] = 0; want[3] = 64'h0000_BEEF_0000_0000;
    ins[4] = 32'hFFFF_FFFF;                    fm[4] = 3'd5; sr[4] = 0; want[4] = 64'h0;
    ins[5] = 32'h0000_0001;                    fm[5] = 3'd3; sr[5] = 1; want[5] = 64'h4;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      send(sr[k], ins[k], fm[k], 4'(k));
      checks++;
      if (out_valid !== 1'b1 || out_imm !== want[k] || out_src !== sr[k]) begin
        failures++;
        $display("FAIL fmt_case%0d got v=%b imm=%h src=%b required v=1 imm=%h src=%b",
                 k, out_valid, out_imm, out_src, want[k], sr[k]);
      end
    end
    step(); step();
  endtask

  task automatic test_back_to_back();
    src_log.delete();
    log_en = 1'b1;
    out_ready = 1'b1;
    fork
      for (int k = 0; k < 4; k++) send(1'b0, $urandom, 3'($urandom_range(0, 4)), 4'(k));
      for (int k = 0; k < 4; k++) send(1'b1, $urandom, 3'($urandom_range(0, 4)), 4'(k));
    join
    step(); step();
    log_en = 1'b0;
    checks++;
    if ((exp_q0.size() + exp_q1.size()) != 0 || src_log.size() != 8) begin
      failures++;
      $display("FAIL b2b_count got pending=%0d results=%0d required pending=0 results=8",
               exp_q0.size() + exp_q1.size(), src_log.size());
    end
    for (int k = 0; k < src_log.size(); k++) begin
      checks++;
      if (src_log[k] !== 1'(k % 2)) begin
        failures++;
        $display("FAIL b2b_order idx=%0d got src=%b required src=%0d", k, src_log[k], k % 2);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] ia, ib, ic;
    ia = 32'h00AB_C000; ib = 32'h0012_3000; ic = 32'h0345_6780;
    out_ready = 1'b0;
    send(1'b1, ia, 3'd0, 4'hA);
    set_req(1'b0, ib, 3'd1, 4'hB);
    set_req(1'b1, ic, 3'd2, 4'hC);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({req0_ready, req1_ready} !== 2'b00 || out_valid !== 1'b1 || out_imm !== ref_imm(ia, 3'd0)) begin
        failures++;
        $display("FAIL bp_hold cyc=%0d got rdy=%b v=%b imm=%h required rdy=00 v=1 imm=%h",
                 k, {req0_ready, req1_ready}, out_valid, out_imm, ref_imm(ia, 3'd0));
      end
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b1) begin failures++; $display("FAIL bp_release got req0_ready=%b required=1", req0_ready); end
    step();
    req0_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_src !== 1'b0 || out_imm !== ref_imm(ib, 3'd1)) begin
      failures++;
      $display("FAIL bp_next got v=%b src=%b imm=%h required v=1 src=0 imm=%h",
               out_valid, out_src, out_imm, ref_imm(ib, 3'd1));
    end
    @(negedge clk);
    checks++;
    if (req1_ready !== 1'b1) begin failures++; $display("FAIL bp_req1 got req1_ready=%b required=1", req1_ready); end
    step();
    req1_valid = 1'b0;
    drain();
    checks++;
    if ((exp_q0.size() + exp_q1.size()) != 0) begin failures++; $display("FAIL bp_drain got pending=%0d required=0", exp_q0.size() + exp_q1.size()); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    send(1'b0, 32'h0010_0000, 3'd1, 4'h3);
    set_req(1'b0, 32'h0000_5400, 3'd0, 4'h4);
    flush = 1'b1;
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b0) begin failures++; $display("FAIL flush_ready got req0_ready=%b required=0", req0_ready); end
    step();
    flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL flush_empty got v=%b busy=%b required 0/0", out_valid, busy); end
    void'(exp_q0.pop_front());
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b1) begin failures++; $display("FAIL flush_resume got req0_ready=%b required=1", req0_ready); end
    step();
    req0_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_tag !== 4'h4) begin failures++; $display("FAIL flush_next got v=%b tag=%h required v=1 tag=4", out_valid, out_tag); end
    drain();
    checks++;
    if (exp_q0.size() != 0) begin failures++; $display("FAIL flush_drain got pending=%0d required=0", exp_q0.size()); end
  endtask

  task automatic test_random();
    rnd_done = 1'b0;
    fork
      begin
        fork
          for (int k = 0; k < 12; k++) send(1'b0, $urandom, 3'($urandom_range(0, 7)), 4'(k));
          for (int k = 0; k < 12; k++) send(1'b1, $urandom, 3'($urandom_range(0, 7)), 4'(k));
        join
        rnd_done = 1'b1;
      end
      while (!rnd_done) begin
        step();
        out_ready = ($urandom_range(0, 3) != 0);
      end
    join
    drain();
    checks++;
    if ((exp_q0.size() + exp_q1.size()) != 0) begin failures++; $display("FAIL rnd_drain got pending=%0d required=0", exp_q0.size() + exp_q1.size()); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    send(1'b0, 32'h0000_0C00, 3'd0, 4'h7);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    void'(exp_q0.pop_front());
    checks++;
    if (out_valid !== 1'b0 || out_imm !== '0 || out_tag !== '0) begin
      failures++;
      $display("FAIL rmid_drop got v=%b imm=%h tag=%h required 0/0/0", out_valid, out_imm, out_tag);
    end
`ifdef IMM_EXT_ERR_CHECK_EN
    checks++; if (err_count !== 8'd0) begin failures++; $display("FAIL rmid_errcnt got=%0d required=0", err_count); end
`endif
    set_req(1'b0, 32'h0000_1000, 3'd1, 4'h1);
    set_req(1'b1, 32'h0000_2000, 3'd1, 4'h2);
    @(negedge clk);
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin failures++; $display("FAIL rmid_tie got rdy=%b required=10", {req0_ready, req1_ready}); end
    step();
    req0_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (req1_ready !== 1'b1) begin failures++; $display("FAIL rmid_req1 got req1_ready=%b required=1", req1_ready); end
    step();
    req1_valid = 1'b0;
    drain();
  endtask

`ifdef IMM_EXT_ERR_CHECK_EN
  task automatic test_err();
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      send(1'b0, $urandom, 3'd6, 4'(k));
      checks++;
      if (out_err !== 1'b1 || out_imm !== '0) begin failures++; $display("FAIL err_flag k=%0d got err=%b imm=%h required err=1 imm=0", k, out_err, out_imm); end
    end
    step();
    checks++;
    if (err_count !== 8'd3) begin failures++; $display("FAIL err_count got=%0d required=3", err_count); end
    drain();
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    log_en = 1'b0;
    fork
      monitor();
    join_none
    test_reset();
    test_formats();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_random();
    test_reset_mid();
`ifdef IMM_EXT_ERR_CHECK_EN
    test_err();
`endif
    checks++;
    if ((exp_q0.size() + exp_q1.size()) != 0) begin
      failures++;
      $display("FAIL final_pending got=%0d required=0", exp_q0.size() + exp_q1.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
